// File: rtl/core_lsu_if.sv
// Bundles for the load/store unit: core-side request/response and memory-side request/response.
interface core_lsu_if #(
    parameter int unsigned data_width_p = 32,
    parameter int unsigned addr_width_p = 32
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    req_wen_i;
    logic [1:0]              req_size_i;
    logic                    req_signed_i;
    logic [addr_width_p-1:0] req_addr_i;
    logic [data_width_p-1:0] req_wdata_i;
    logic                    rsp_valid_o;
    logic [data_width_p-1:0] rsp_data_o;
    logic                    rsp_yumi_i;
    logic                    misalign_o;
    logic                    exception_o;

    // master = execute stage, slave = LSU
    modport master (
        output req_valid_i, req_wen_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i, rsp_yumi_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, misalign_o, exception_o
    );
    modport slave (
        input  req_valid_i, req_wen_i, req_size_i, req_signed_i, req_addr_i, req_wdata_i, rsp_yumi_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, misalign_o, exception_o
    );
endinterface

interface core_lsu_mem_if #(
    parameter int unsigned data_width_p = 32,
    parameter int unsigned addr_width_p = 32
);
    localparam int unsigned nb_lp = data_width_p / 8;

    logic                    mem_valid_o;
    logic                    mem_wen_o;
    logic [addr_width_p-1:0] mem_addr_o;
    logic [nb_lp-1:0]        mem_be_o;
    logic [data_width_p-1:0] mem_wdata_o;
    logic                    mem_yumi_i;
    logic                    mem_rsp_valid_i;
    logic [data_width_p-1:0] mem_rsp_data_i;
    logic                    mem_rsp_yumi_o;

    // master = LSU, slave = data memory
    modport master (
        output mem_valid_o, mem_wen_o, mem_addr_o, mem_be_o, mem_wdata_o, mem_rsp_yumi_o,
        input  mem_yumi_i, mem_rsp_valid_i, mem_rsp_data_i
    );
    modport slave (
        input  mem_valid_o, mem_wen_o, mem_addr_o, mem_be_o, mem_wdata_o, mem_rsp_yumi_o,
        output mem_yumi_i, mem_rsp_valid_i, mem_rsp_data_i
    );
endinterface

// File: rtl/core_lsu.sv
// Load/store unit: throttled issue, one-entry request register, tag FIFO for in-order responses,
// load alignment/extension, store lane replication and sticky error reporting.
module core_lsu #(
    parameter int unsigned data_width_p      = 32,
    parameter int unsigned addr_width_p      = 32,
    parameter int unsigned max_outstanding_p = 2,
    parameter int unsigned throttle_period_p = 5
) (
    input  logic           clk,
    input  logic           reset,
    core_lsu_if.slave      core,
    core_lsu_mem_if.master mem
);
    localparam int unsigned nb_lp        = data_width_p / 8;
    localparam int unsigned ob_lp        = $clog2(nb_lp);
    localparam int unsigned tc_width_lp  = (throttle_period_p > 1) ? $clog2(throttle_period_p) : 1;
    localparam int unsigned ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int unsigned cnt_width_lp = $clog2(max_outstanding_p + 1);

    typedef struct packed {
        logic             wen;
        logic [1:0]       size;
        logic             sgn;
        logic [ob_lp-1:0] off;
    } tag_t;

    logic [tc_width_lp-1:0]  tc_q;
    logic                    throttle_ok;
    logic                    req_full_q;
    logic                    req_wen_q;
    logic [addr_width_p-1:0] req_addr_q;
    logic [nb_lp-1:0]        req_be_q;
    logic [data_width_p-1:0] req_wdata_q;
    logic [cnt_width_lp-1:0] outstanding_q;
    logic                    exception_q;
    logic                    misalign_q;
    logic                    rsp_valid_q;
    logic [data_width_p-1:0] rsp_data_q;

    logic [ob_lp-1:0]        addr_off;
    logic                    size_ok;
    logic                    align_ok;
    logic                    legal;
    logic                    ready;
    logic                    accept;
    logic                    push;
    logic                    pop;
    logic                    mem_rsp_take;
    logic                    rsp_retire;
    logic [nb_lp-1:0]        be_next;
    logic [data_width_p-1:0] wdata_rep;

    tag_t                    fifo_q [max_outstanding_p];
    logic [ptr_width_lp-1:0] wr_ptr_q;
    logic [ptr_width_lp-1:0] rd_ptr_q;
    logic [cnt_width_lp-1:0] fifo_cnt_q;
    logic                    fifo_empty;
    tag_t                    rd_tag;

    logic [data_width_p-1:0] shifted;
    logic [data_width_p-1:0] ext;
    logic                    ext_sign;
    logic [31:0]             keep_bits;

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // Throttle counter runs only while the core holds a request.
    assign throttle_ok = (tc_q == tc_width_lp'(throttle_period_p - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  tc_q <= '0;
        else if (!core.req_valid_i) tc_q <= '0;
        else if (throttle_ok)       tc_q <= '0;
        else                        tc_q <= tc_q + tc_width_lp'(1);
    end

    // Request legality, byte enables and lane-replicated store data.
    always_comb begin
        addr_off = core.req_addr_i[ob_lp-1:0];
        size_ok  = (32'(core.req_size_i) <= ob_lp);
        align_ok = ((addr_off & ob_lp'((32'd1 << core.req_size_i) - 32'd1)) == '0);
        legal    = size_ok & align_ok;
        be_next  = nb_lp'(((64'd1 << (32'd1 << core.req_size_i)) - 64'd1) << addr_off);
    end

    for (genvar g = 0; g < data_width_p; g++) begin : g_repl
        assign wdata_rep[g] = (core.req_size_i == 2'd0) ? core.req_wdata_i[g % 8]  :
                              (core.req_size_i == 2'd1) ? core.req_wdata_i[g % 16] :
                              (core.req_size_i == 2'd2) ? core.req_wdata_i[g % 32] :
                                                          core.req_wdata_i[g];
    end

    // Reset gating keeps the combinational handshakes low while reset is held.
    assign ready        = throttle_ok & ~req_full_q
                        & (outstanding_q < cnt_width_lp'(max_outstanding_p))
                        & ~exception_q & ~reset;
    assign accept       = core.req_valid_i & ready;
    assign push         = accept & legal;
    assign mem_rsp_take = mem.mem_rsp_valid_i & (~rsp_valid_q | core.rsp_yumi_i) & ~reset;
    assign fifo_empty   = (fifo_cnt_q == '0);
    assign pop          = mem_rsp_take & ~fifo_empty;
    assign rsp_retire   = rsp_valid_q & core.rsp_yumi_i;

    // One-entry request register, freed when memory accepts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_full_q  <= 1'b0;
            req_wen_q   <= 1'b0;
            req_addr_q  <= '0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
        end else if (push) begin
            req_full_q  <= 1'b1;
            req_wen_q   <= core.req_wen_i;
            req_addr_q  <= {core.req_addr_i[addr_width_p-1:ob_lp], ob_lp'(0)};
            req_be_q    <= be_next;
            req_wdata_q <= wdata_rep;
        end else if (req_full_q && mem.mem_yumi_i) begin
            req_full_q  <= 1'b0;
        end
    end

    // Tag FIFO storage; pointers and count carry the reset state.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{wen: core.req_wen_i, size: core.req_size_i,
                                        sgn: core.req_signed_i, off: addr_off};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + cnt_width_lp'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - cnt_width_lp'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // Outstanding counts from accept until the core retires the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding_q <= '0;
        end else begin
            case ({push, rsp_retire})
                2'b10:   outstanding_q <= outstanding_q + cnt_width_lp'(1);
                2'b01:   outstanding_q <= outstanding_q - cnt_width_lp'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Load alignment and extension from the oldest tag.
    always_comb begin
        rd_tag    = fifo_q[rd_ptr_q];
        shifted   = mem.mem_rsp_data_i >> {rd_tag.off, 3'b000};
        keep_bits = 32'd8 << rd_tag.size;
        case (rd_tag.size)
            2'd0:    ext_sign = rd_tag.sgn & shifted[7];
            2'd1:    ext_sign = rd_tag.sgn & shifted[15];
            2'd2:    ext_sign = rd_tag.sgn & shifted[31];
            default: ext_sign = rd_tag.sgn & shifted[data_width_p-1];
        endcase
    end

    for (genvar g = 0; g < data_width_p; g++) begin : g_ext
        assign ext[g] = (g < keep_bits) ? shifted[g] : ext_sign;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (pop) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rd_tag.wen ? '0 : ext;
        end else if (rsp_retire) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Misalign pulse and sticky exception (illegal request or unsolicited memory response).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q  <= 1'b0;
            exception_q <= 1'b0;
        end else begin
            misalign_q <= accept & ~legal;
            if ((accept & ~legal) | (mem_rsp_take & fifo_empty)) exception_q <= 1'b1;
        end
    end

    assign core.req_ready_o = ready;
    assign core.rsp_valid_o = rsp_valid_q;
    assign core.rsp_data_o  = rsp_data_q;
    assign core.misalign_o  = misalign_q;
    assign core.exception_o = exception_q;

    assign mem.mem_valid_o    = req_full_q;
    assign mem.mem_wen_o      = req_wen_q;
    assign mem.mem_addr_o     = req_addr_q;
    assign mem.mem_be_o       = req_be_q;
    assign mem.mem_wdata_o    = req_wdata_q;
    assign mem.mem_rsp_yumi_o = mem_rsp_take;
endmodule

// File: tb/tb_core_lsu.sv
// Scoreboard bench for core_lsu: directed loads/stores, throttle, outstanding limit and errors.
module tb_core_lsu;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    core_lsu_if     #(.data_width_p(32), .addr_width_p(32)) cif  ();
    core_lsu_mem_if #(.data_width_p(32), .addr_width_p(32)) mif  ();
    core_lsu_if     #(.data_width_p(32), .addr_width_p(32)) cif5 ();
    core_lsu_mem_if #(.data_width_p(32), .addr_width_p(32)) mif5 ();

    core_lsu #(.data_width_p(32), .addr_width_p(32), .max_outstanding_p(2), .throttle_period_p(1))
        dut (.clk(clk), .reset(reset), .core(cif.slave), .mem(mif.master));
    core_lsu #(.data_width_p(32), .addr_width_p(32), .max_outstanding_p(2), .throttle_period_p(5))
        dut5 (.clk(clk), .reset(reset), .core(cif5.slave), .mem(mif5.master));

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    int errors = 0;
    int checks = 0;
    mreq_t       exp_mem[$];
    logic [31:0] exp_rsp[$];
    logic [31:0] mrsp_q[$];
    logic [31:0] mem_words [16];
    logic mem_accept_en, rsp_en, inj, core_yumi_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    assign mif.mem_yumi_i   = mif.mem_valid_o & mem_accept_en;
    assign cif.rsp_yumi_i   = core_yumi_en;
    assign mif5.mem_yumi_i  = mif5.mem_valid_o;
    assign mif5.mem_rsp_valid_i = 1'b0;
    assign mif5.mem_rsp_data_i  = '0;
    assign cif5.rsp_yumi_i  = 1'b1;

    // Memory model + request monitor for the main DUT.
    always @(negedge clk) begin
        if (!reset) begin
            if (mif.mem_rsp_valid_i && mif.mem_rsp_yumi_o && !inj && mrsp_q.size() > 0)
                void'(mrsp_q.pop_front());
            if (mif.mem_valid_o && mif.mem_yumi_i) begin
                if (exp_mem.size() == 0) begin
                    errors++;
                    $display("FAIL mem_req: unexpected request addr 0x%0h", mif.mem_addr_o);
                end else begin
                    mreq_t e;
                    e = exp_mem.pop_front();
                    checks++;
                    if (mif.mem_wen_o !== e.wen || mif.mem_addr_o !== e.addr || mif.mem_be_o !== e.be ||
                        (e.wen && mif.mem_wdata_o !== e.wdata)) begin
                        errors++;
                        $display("FAIL mem_req: got wen=%0b addr=0x%0h be=%b wdata=0x%0h, want wen=%0b addr=0x%0h be=%b wdata=0x%0h",
                                 mif.mem_wen_o, mif.mem_addr_o, mif.mem_be_o, mif.mem_wdata_o,
                                 e.wen, e.addr, e.be, e.wdata);
                    end
                end
                if (mif.mem_wen_o) begin
                    for (int b = 0; b < 4; b++)
                        if (mif.mem_be_o[b]) mem_words[mif.mem_addr_o[5:2]][8*b +: 8] = mif.mem_wdata_o[8*b +: 8];
                end
                mrsp_q.push_back(mem_words[mif.mem_addr_o[5:2]]);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        mif.mem_rsp_valid_i = inj || (rsp_en && mrsp_q.size() > 0);
        mif.mem_rsp_data_i  = inj ? 32'hDEAD_0000 : ((mrsp_q.size() > 0) ? mrsp_q[0] : 32'h0);
    end

    // Core response monitor.
    always @(negedge clk) begin
        if (!reset && cif.rsp_valid_o && cif.rsp_yumi_i) begin
            if (exp_rsp.size() == 0) begin
                errors++;
                $display("FAIL rsp: unexpected response 0x%0h", cif.rsp_data_o);
            end else begin
                check("rsp_data", cif.rsp_data_o, exp_rsp.pop_front());
            end
        end
    end

    task automatic issue(input logic wen, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic legal, input logic [31:0] eaddr,
                         input logic [3:0] ebe, input logic [31:0] ewdata, input logic [31:0] ersp);
        int n;
        @(posedge clk); #1;
        cif.req_valid_i = 1'b1; cif.req_wen_i = wen; cif.req_size_i = size;
        cif.req_signed_i = sgn; cif.req_addr_i = addr; cif.req_wdata_i = wdata;
        n = 0;
        forever begin
            @(negedge clk);
            if (cif.req_ready_o) break;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL issue_timeout: addr 0x%0h never accepted", addr);
                break;
            end
        end
        if (legal && cif.req_ready_o) begin
            exp_mem.push_back('{wen, eaddr, ebe, ewdata});
            exp_rsp.push_back(ersp);
        end
        @(posedge clk); #1;
        cif.req_valid_i = 1'b0;
    endtask

    task automatic hold_lw(input int ncyc, output logic [15:0] pat);
        pat = '0;
        @(posedge clk); #1;
        cif.req_valid_i = 1'b1; cif.req_wen_i = 1'b0; cif.req_size_i = 2'd2;
        cif.req_signed_i = 1'b0; cif.req_addr_i = 32'h8; cif.req_wdata_i = '0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            pat[4'(i)] = cif.req_ready_o;
            if (cif.req_ready_o) begin
                exp_mem.push_back('{1'b0, 32'h8, 4'hF, 32'h0});
                exp_rsp.push_back(32'hDEAD_BEEF);
            end
        end
        @(posedge clk); #1;
        cif.req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200 && (exp_rsp.size() > 0 || exp_mem.size() > 0); n++) @(negedge clk);
        check("drain_rsp", 32'(exp_rsp.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        cif.req_valid_i = 1'b0;
        inj = 1'b0;
        @(negedge clk);
        check("reset_exception", 32'(cif.exception_o), 32'd0);
        check("reset_mem_valid", 32'(mif.mem_valid_o), 32'd0);
        repeat (2) @(posedge clk);
        exp_mem.delete(); exp_rsp.delete(); mrsp_q.delete();
        #1 reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        logic [15:0] mv5;
        int lat;
        reset = 1'b1;
        mem_accept_en = 1'b1; rsp_en = 1'b1; inj = 1'b0; core_yumi_en = 1'b1;
        cif.req_valid_i = 1'b0; cif.req_wen_i = 1'b0; cif.req_size_i = 2'd0;
        cif.req_signed_i = 1'b0; cif.req_addr_i = '0; cif.req_wdata_i = '0;
        cif5.req_valid_i = 1'b0; cif5.req_wen_i = 1'b0; cif5.req_size_i = 2'd2;
        cif5.req_signed_i = 1'b0; cif5.req_addr_i = '0; cif5.req_wdata_i = '0;
        mif.mem_rsp_valid_i = 1'b0; mif.mem_rsp_data_i = '0;
        for (int i = 0; i < 16; i++) mem_words[i] = 32'h0;
        mem_words[0] = 32'h1122_5A5A;
        mem_words[4] = 32'h8000_00F0;

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(cif.req_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(cif.rsp_valid_o), 32'd0);
        check("rst_mem_valid", 32'(mif.mem_valid_o), 32'd0);
        check("rst_misalign", 32'(cif.misalign_o), 32'd0);
        check("rst_exception", 32'(cif.exception_o), 32'd0);
        check("rst_mem_rsp_yumi", 32'(mif.mem_rsp_yumi_o), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cif.req_ready_o), 32'd1);

        // Throttle period 5 with held valid
        @(posedge clk); #1 cif5.req_valid_i = 1'b1;
        pat = '0; mv5 = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pat[4'(i)] = cif5.req_ready_o;
            mv5[4'(i)] = mif5.mem_valid_o;
        end
        @(posedge clk); #1 cif5.req_valid_i = 1'b0;
        check("thr5_ready_pattern", 32'(pat), 32'h0210);
        check("thr5_mem_valid_pattern", 32'(mv5), 32'h0020);

        // Directed loads and stores
        issue(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b1, 32'h10, 4'hF, 32'h0, 32'h8000_00F0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (cif.rsp_valid_o) break;
        end
        check("lw_latency", 32'(lat), 32'd3);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 32'h10, 4'b1000, 32'h0, 32'hFFFF_FF80);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 32'h10, 4'b1000, 32'h0, 32'h0000_0080);
        issue(1'b1, 2'd1, 1'b0, 32'h2,  32'h1234_ABCD, 1'b1, 32'h0, 4'b1100, 32'hABCD_ABCD, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h2,  32'h0, 1'b1, 32'h0, 4'b1100, 32'h0, 32'hFFFF_ABCD);
        issue(1'b0, 2'd1, 1'b0, 32'h0,  32'h0, 1'b1, 32'h0, 4'b0011, 32'h0, 32'h0000_5A5A);
        issue(1'b0, 2'd0, 1'b1, 32'h1,  32'h0, 1'b1, 32'h0, 4'b0010, 32'h0, 32'h0000_005A);
        issue(1'b1, 2'd0, 1'b0, 32'h5,  32'h0000_0077, 1'b1, 32'h4, 4'b0010, 32'h7777_7777, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h5,  32'h0, 1'b1, 32'h4, 4'b0010, 32'h0, 32'h0000_0077);
        issue(1'b1, 2'd2, 1'b0, 32'h8,  32'hDEAD_BEEF, 1'b1, 32'h8, 4'hF, 32'hDEAD_BEEF, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h8,  32'h0, 1'b1, 32'h8, 4'hF, 32'h0, 32'hDEAD_BEEF);
        issue(1'b0, 2'd1, 1'b1, 32'h8,  32'h0, 1'b1, 32'h8, 4'b0011, 32'h0, 32'hFFFF_BEEF);
        issue(1'b0, 2'd1, 1'b0, 32'hA,  32'h0, 1'b1, 32'h8, 4'b1100, 32'h0, 32'h0000_DEAD);
        wait_idle();

        // Outstanding limit: no memory responses, core not consuming
        rsp_en = 1'b0; core_yumi_en = 1'b0;
        hold_lw(6, pat);
        check("max_outstanding_pattern", 32'(pat), 32'h0005);
        rsp_en = 1'b1;
        repeat (4) @(negedge clk);
        check("bp_rsp_valid", 32'(cif.rsp_valid_o), 32'd1);
        check("bp_mem_rsp_valid", 32'(mif.mem_rsp_valid_i), 32'd1);
        check("bp_mem_rsp_yumi", 32'(mif.mem_rsp_yumi_o), 32'd0);
        check("bp_ready_blocked", 32'(cif.req_ready_o), 32'd0);
        @(posedge clk); #1 core_yumi_en = 1'b1;
        wait_idle();
        @(negedge clk);
        check("ready_after_retire", 32'(cif.req_ready_o), 32'd1);

        // Misaligned word load
        issue(1'b0, 2'd2, 1'b1, 32'h2, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("misalign_pulse", 32'(cif.misalign_o), 32'd1);
        check("misalign_exception", 32'(cif.exception_o), 32'd1);
        check("misalign_no_mem", 32'(mif.mem_valid_o), 32'd0);
        @(negedge clk);
        check("misalign_pulse_end", 32'(cif.misalign_o), 32'd0);
        check("exception_sticky", 32'(cif.exception_o), 32'd1);
        check("exception_blocks", 32'(cif.req_ready_o), 32'd0);

        // Dword on a 32-bit datapath is an illegal size
        do_reset();
        issue(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("bad_size_misalign", 32'(cif.misalign_o), 32'd1);
        check("bad_size_no_mem", 32'(mif.mem_valid_o), 32'd0);

        // Unsolicited memory response
        do_reset();
        @(posedge clk); #1 inj = 1'b1;
        @(negedge clk);
        check("unsol_yumi", 32'(mif.mem_rsp_yumi_o), 32'd1);
        @(posedge clk); #1 inj = 1'b0;
        @(negedge clk);
        check("unsol_exception", 32'(cif.exception_o), 32'd1);
        check("unsol_no_rsp", 32'(cif.rsp_valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
